// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator controller slice.
package elevator_pkg;

  localparam int unsigned FLOORS = 6;

  typedef logic [FLOORS:1] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    DOOR_OPEN,
    MOVE_UP,
    MOVE_DOWN
  } state_e;

  // All-zero and multi-hot vectors are treated as "no request".
  function automatic logic onehot_valid(floor_t f);
    return (f != '0) && ((f & (f - floor_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Clearable up-counter shared by the door dwell and travel phases.
module elevator_timer #(
  parameter int unsigned MAX_CYCLES = 100
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clr_i,
  input  logic [((MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1)-1:0] tc_i,
  output logic                                          done_o
);

  localparam int unsigned W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/elevator_controller.sv
// Six-floor elevator sequencer: owns car position, door dwell and travel timing,
// and freezes the request latch (closeDoor) while the car is moving.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 50,
  parameter int unsigned DOOR_CYCLES   = 100
) (
  input  logic   clk,
  input  logic   reset,
  input  floor_t whichFloor,
  input  logic   openBtn,
  output logic   closeDoor,
  output floor_t currentFloor,
  output logic   doorOpen,
  output logic   up,
  output logic   down
);

  localparam int unsigned MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_TC = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_TC   = TW'(DOOR_CYCLES - 1);

  state_e        state_q, state_d;
  floor_t        floor_q, floor_d;
  logic          tmr_clr;
  logic          tmr_done;
  logic [TW-1:0] tmr_tc;
  logic          tgt_valid;

  assign tgt_valid = onehot_valid(whichFloor);
  assign tmr_tc    = (state_q == DOOR_OPEN) ? DOOR_TC : TRAVEL_TC;

  elevator_timer #(
    .MAX_CYCLES(MAX_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (tmr_clr),
    .tc_i  (tmr_tc),
    .done_o(tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DOOR_OPEN;
      floor_q <= floor_t'(1);
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    tmr_clr = 1'b0;
    unique case (state_q)
      DOOR_OPEN: begin
        if (openBtn) begin
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end
      end
      IDLE: begin
        // Timer is held at zero so every exit from IDLE starts a fresh count.
        tmr_clr = 1'b1;
        if (openBtn) begin
          state_d = DOOR_OPEN;
        end else if (tgt_valid && (whichFloor > floor_q)) begin
          state_d = MOVE_UP;
        end else if (tgt_valid && (whichFloor < floor_q)) begin
          state_d = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (tmr_done) begin
          tmr_clr = 1'b1;
          if (floor_q[FLOORS]) begin
            state_d = DOOR_OPEN;
          end else begin
            floor_d = floor_q << 1;
            if (floor_d == whichFloor) begin
              state_d = DOOR_OPEN;
            end
          end
        end
      end
      MOVE_DOWN: begin
        if (tmr_done) begin
          tmr_clr = 1'b1;
          if (floor_q[1]) begin
            state_d = DOOR_OPEN;
          end else begin
            floor_d = floor_q >> 1;
            if (floor_d == whichFloor) begin
              state_d = DOOR_OPEN;
            end
          end
        end
      end
      default: begin
        state_d = DOOR_OPEN;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    closeDoor = 1'b0;
    doorOpen  = 1'b0;
    up        = 1'b0;
    down      = 1'b0;
    unique case (state_q)
      IDLE:      closeDoor = 1'b1;
      DOOR_OPEN: doorOpen  = 1'b1;
      MOVE_UP:   up        = 1'b1;
      MOVE_DOWN: down      = 1'b1;
      default:   doorOpen  = 1'b0;
    endcase
  end

  assign currentFloor = floor_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller driven through a model of the request latch.
module tb_elevator_controller;
  import elevator_pkg::*;

  localparam int unsigned TRAVEL = 4;
  localparam int unsigned DOOR   = 3;

  logic   clk     = 1'b0;
  logic   reset   = 1'b0;
  logic   openBtn = 1'b0;
  floor_t sw      = '0;
  floor_t whichFloor;
  logic   closeDoor, doorOpen, up, down;
  floor_t currentFloor;

  int tests  = 0;
  int failed = 0;

  logic [9:0] sb[$];
  logic [9:0] obs;
  logic [9:0] exp_v;

  assign obs = {closeDoor, doorOpen, up, down, currentFloor};

  always #5 clk = ~clk;

  // Request latch: tracks the switches only while closeDoor is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) whichFloor <= '0;
    else if (closeDoor) whichFloor <= sw;
  end

  elevator_controller #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .whichFloor  (whichFloor),
    .openBtn     (openBtn),
    .closeDoor   (closeDoor),
    .currentFloor(currentFloor),
    .doorOpen    (doorOpen),
    .up          (up),
    .down        (down)
  );

  function automatic floor_t fl(int n);
    return floor_t'(1) << (n - 1);
  endfunction

  // Packs {closeDoor, doorOpen, up, down, currentFloor}.
  function automatic logic [9:0] st(logic c, logic d, logic u, logic dn, floor_t f);
    return {c, d, u, dn, f};
  endfunction

  task automatic test_reset();
    reset = 1'b0; sw = '0; openBtn = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (obs !== st(0, 1, 0, 0, fl(1))) begin
      failed++;
      $display("FAIL reset_hold: got %b want %b", obs, st(0, 1, 0, 0, fl(1)));
    end
    reset = 1'b1;
    repeat (DOOR - 1) sb.push_back(st(0, 1, 0, 0, fl(1)));
    repeat (3) sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL reset_release cycle %0d: got %b want %b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_up_trip();
    sw = fl(6);
    sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int i = 0; i < 20; i++) sb.push_back(st(0, 0, 1, 0, fl(1 + i / 4)));
    repeat (DOOR) sb.push_back(st(0, 1, 0, 0, fl(6)));
    repeat (3) sb.push_back(st(1, 0, 0, 0, fl(6)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL up_trip cycle %0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 8)  sw = fl(1);
      if (n == 16) sw = fl(6);
    end
  endtask

  task automatic test_down_trip();
    sw = fl(2);
    sb.push_back(st(1, 0, 0, 0, fl(6)));
    for (int i = 0; i < 16; i++) sb.push_back(st(0, 0, 0, 1, fl(6 - i / 4)));
    repeat (DOOR) sb.push_back(st(0, 1, 0, 0, fl(2)));
    repeat (2) sb.push_back(st(1, 0, 0, 0, fl(2)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL down_trip cycle %0d: got %b want %b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_no_motion();
    floor_t pats[3];
    pats[0] = '0;
    pats[1] = 6'b010100;
    pats[2] = fl(1);
    reset = 1'b0; sw = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (DOOR - 1) sb.push_back(st(0, 1, 0, 0, fl(1)));
    sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int p = 0; p < 3; p++) begin
      if (p > 0) sw = pats[p];
      repeat (5) sb.push_back(st(1, 0, 0, 0, fl(1)));
      for (int n = 0; sb.size() > 0; n++) begin
        @(negedge clk);
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
          failed++;
          $display("FAIL no_motion pat %0d cycle %0d: got %b want %b", p, n, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_open_btn();
    openBtn = 1'b1;
    repeat (10) sb.push_back(st(0, 1, 0, 0, fl(1)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL open_hold cycle %0d: got %b want %b", n, obs, exp_v);
      end
    end
    openBtn = 1'b0;
    repeat (DOOR - 1) sb.push_back(st(0, 1, 0, 0, fl(1)));
    repeat (2) sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL open_release cycle %0d: got %b want %b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    sw = fl(4); openBtn = 1'b1;
    repeat (DOOR) sb.push_back(st(0, 1, 0, 0, fl(1)));
    sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int i = 0; i < 12; i++) sb.push_back(st(0, 0, 1, 0, fl(1 + i / 4)));
    repeat (DOOR) sb.push_back(st(0, 1, 0, 0, fl(4)));
    sb.push_back(st(1, 0, 0, 0, fl(4)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL simultaneous cycle %0d: got %b want %b", n, obs, exp_v);
      end
      if (n == 0)  openBtn = 1'b0;
      if (n == 9)  openBtn = 1'b1;
      if (n == 11) openBtn = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    reset = 1'b0; sw = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (DOOR - 1) sb.push_back(st(0, 1, 0, 0, fl(1)));
    sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL async_prep cycle %0d: got %b want %b", n, obs, exp_v);
      end
    end
    sw = fl(5);
    sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int i = 0; i < 10; i++) sb.push_back(st(0, 0, 1, 0, fl(1 + i / 4)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL async_trip cycle %0d: got %b want %b", n, obs, exp_v);
      end
    end
    #2;
    sw = '0;
    reset = 1'b0;
    #1;
    tests++;
    if (obs !== st(0, 1, 0, 0, fl(1))) begin
      failed++;
      $display("FAIL async_snap: got %b want %b", obs, st(0, 1, 0, 0, fl(1)));
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (DOOR - 1) sb.push_back(st(0, 1, 0, 0, fl(1)));
    repeat (2) sb.push_back(st(1, 0, 0, 0, fl(1)));
    for (int n = 0; sb.size() > 0; n++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL async_recover cycle %0d: got %b want %b", n, obs, exp_v);
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "time limit exceeded");
  end

  initial begin
    test_reset();
    test_up_trip();
    test_down_trip();
    test_no_motion();
    test_open_btn();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
Central sequencer for the six-floor elevator. It owns the current-floor register, the door dwell timer and the travel timer. It drives the closeDoor enable of the floor-request latch, so the latched target floor (whichFloor) is frozen while the car travels. It sits between the request latch and the display/motor outputs.

Parameters:
FLOORS, 6, number of floors; the one-hot floor vectors are [FLOORS:1].
TRAVEL_CYCLES, 50, clock cycles to move one floor (must be >= 1).
DOOR_CYCLES, 100, clock cycles the door stays open (must be >= 1).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
whichFloor  input  [FLOORS:1]  latched target floor, one-hot, from the request latch.
openBtn  input  1  door-open request, level-sensitive.
closeDoor  output  1  enable to the request latch; 1 = latch samples switches.
currentFloor  output  [FLOORS:1]  one-hot car position.
doorOpen  output  1  door is open.
up  output  1  car is moving up.
down  output  1  car is moving down.

Behaviour:
- Async reset (reset==0): without waiting for a clock edge, state=DOOR_OPEN, currentFloor=000001, timer=0, doorOpen=1, closeDoor=0, up=0, down=0. This holds mid-trip too; the car snaps to floor 1.
- Outputs decode only the registered state (Moore). There are no combinational input-to-output paths.
- Valid target: whichFloor is exactly one-hot. All-zero or multi-hot counts as no request.
- One shared timer counts 0..N-1. Entering any state clears it to 0.
- DOOR_OPEN: doorOpen=1. openBtn=1 forces timer to 0. When timer==DOOR_CYCLES-1 and openBtn=0, go to IDLE.
- IDLE: door closed and closeDoor=1 every cycle, so the latch tracks the switches.
  - The latch is registered, so a switch change reaches whichFloor one cycle later and IDLE reacts on the following edge.
  - Priority: openBtn -> DOOR_OPEN; else valid target above currentFloor -> MOVE_UP; else valid target below -> MOVE_DOWN; else stay in IDLE.
  - closeDoor deasserts in the first MOVE cycle, freezing the target.
- MOVE_UP / MOVE_DOWN: up=1 or down=1 respectively. closeDoor=0. openBtn is ignored.
  - When timer==TRAVEL_CYCLES-1, currentFloor shifts one position (left for up, right for down) and timer returns to 0.
  - If the new floor equals the target, go to DOOR_OPEN on that same edge.
- Boundaries:
  - currentFloor never shifts past floor FLOORS or floor 1. If a move would exceed a boundary (defensive case), go to DOOR_OPEN instead.
  - A target equal to currentFloor in IDLE causes no motion.
- Latency:
  - A request reaches MOVE 2 edges after the switch change.
  - A trip of k floors takes k*TRAVEL_CYCLES cycles from MOVE entry to DOOR_OPEN.
- Simultaneous events: openBtn together with a valid request in IDLE resolves to DOOR_OPEN; the request is served after the door closes.

Decomposition:
- elevator_pkg holds:
  - state enum {IDLE, DOOR_OPEN, MOVE_UP, MOVE_DOWN};
  - FLOORS constant;
  - typedef floor_t = logic [FLOORS:1];
  - onehot_valid function.
- Sub-module elevator_timer: clearable up-counter with async active-low reset, a terminal-count input and a done output. It is width-sized from max(TRAVEL_CYCLES, DOOR_CYCLES) and instantiated once.

Test Plan:
All scenarios use TRAVEL_CYCLES=4 and DOOR_CYCLES=3, with the controller connected to the request latch.
1. Reset low, then released -> currentFloor=000001, doorOpen=1, closeDoor=0; after 3 cycles doorOpen=0, closeDoor=1 (IDLE).
2. In IDLE set SW=100000 -> whichFloor=100000 next cycle; MOVE_UP next, with up=1 and closeDoor=0. The floor advances every 4 cycles and reaches 100000 after 20 cycles, then doorOpen=1. A SW change mid-trip does not alter the target.
3. From floor 6 set SW=000010 -> MOVE_DOWN, down=1; reaches 000010 after 16 cycles, then DOOR_OPEN.
4. SW=000000, then SW=010100, in IDLE at floor 1 -> no motion, closeDoor stays 1.
5. Hold openBtn in DOOR_OPEN for 10 cycles -> door remains open until 3 cycles after release. openBtn in IDLE -> DOOR_OPEN on the next edge.
6. Drive reset low asynchronously mid-MOVE_UP at floor 3 -> currentFloor=000001, doorOpen=1, up=0 before the next clk edge.
